// File: rtl/md5_pkg.sv
// md5_pkg: shared types and constants for the MD5 message padder.
//   state_t      padder FSM states
//   WORD_LEN     bits per message word
//   BLOCK_WORDS  words per 512-bit block
//   PAD_MARKER   first padding byte appended after the message
//   LEN_LO_IDX / LEN_HI_IDX  word slots holding the 64-bit bit length
package md5_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_LEN,
        S_EMIT
    } state_t;

    localparam int         WORD_LEN    = 32;
    localparam int         BLOCK_WORDS = 16;
    localparam logic [7:0] PAD_MARKER  = 8'h80;
    localparam logic [3:0] LEN_LO_IDX  = 4'd14;
    localparam logic [3:0] LEN_HI_IDX  = 4'd15;

    // Final beat: keep the first nb bytes, put the marker right after them, zero the rest.
    function automatic logic [WORD_LEN-1:0] last_word(input logic [WORD_LEN-1:0] d, input logic [2:0] nb);
        logic [WORD_LEN-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nb))
                w[8*k+:8] = d[8*k+:8];
            else if (k == int'(nb))
                w[8*k+:8] = PAD_MARKER;
        end
        return w;
    endfunction

endpackage

// File: rtl/md5_pad.sv
// md5_pad: packs a little-endian 32-bit word stream into MD5-padded 512-bit blocks.
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_valid/s_ready/s_data         message word stream (byte k at s_data[8k+:8])
//   s_last/s_nbytes                final beat marker and its valid byte count (5..7 act as 4)
//   blk_valid/blk_ready/blk_data   padded block handshake, word i at blk_data[32i+:32]
//   blk_last                       block carries the length field
//   blk_idx                        block index within the current message
module md5_pad
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic [31:0]  blk_idx
);

    state_t              state_q, state_d;
    logic [3:0]          widx_q, widx_d;
    logic [60:0]         bytecnt_q, bytecnt_d;
    logic                marker_done_q, marker_done_d;
    logic                emit_final_q, emit_final_d;
    logic                resume_pad_q, resume_pad_d;
    logic [31:0]         blk_idx_q, blk_idx_d;
    logic [WORD_LEN-1:0] buf_q [BLOCK_WORDS];
    logic [2:0]          nb;
    logic                acc, wr_en, len_en;
    logic [WORD_LEN-1:0] wr_data;
    logic [63:0]         bitlen;

    assign nb     = s_nbytes > 3'd4 ? 3'd4 : s_nbytes;
    assign acc    = s_valid && s_ready;
    assign bitlen = {bytecnt_q, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            widx_q        <= '0;
            bytecnt_q     <= '0;
            marker_done_q <= 1'b0;
            emit_final_q  <= 1'b0;
            resume_pad_q  <= 1'b0;
            blk_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            bytecnt_q     <= bytecnt_d;
            marker_done_q <= marker_done_d;
            emit_final_q  <= emit_final_d;
            resume_pad_q  <= resume_pad_d;
            blk_idx_q     <= blk_idx_d;
        end
    end

    // Every word of a block is rewritten before emission, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            buf_q[widx_q] <= wr_data;
        if (len_en) begin
            buf_q[LEN_LO_IDX] <= bitlen[31:0];
            buf_q[LEN_HI_IDX] <= bitlen[63:32];
        end
    end

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        bytecnt_d     = bytecnt_q;
        marker_done_d = marker_done_q;
        emit_final_d  = emit_final_q;
        resume_pad_d  = resume_pad_q;
        blk_idx_d     = blk_idx_q;
        wr_en         = 1'b0;
        len_en        = 1'b0;
        wr_data       = '0;
        case (state_q)
            S_FILL: if (acc) begin
                wr_en     = 1'b1;
                wr_data   = s_last ? last_word(s_data, nb) : s_data;
                widx_d    = widx_q + 4'd1;
                bytecnt_d = bytecnt_q + (s_last ? 61'(nb) : 61'd4);
                if (s_last) begin
                    marker_done_d = nb < 3'd4;
                    resume_pad_d  = 1'b1;
                    emit_final_d  = 1'b0;
                    state_d       = widx_q == 4'd15 ? S_EMIT : S_PAD;
                end else if (widx_q == 4'd15) begin
                    state_d      = S_EMIT;
                    emit_final_d = 1'b0;
                    resume_pad_d = 1'b0;
                end
            end
            S_PAD: begin
                if (widx_q == LEN_LO_IDX && marker_done_q) begin
                    state_d = S_LEN;
                end else begin
                    wr_en         = 1'b1;
                    wr_data       = marker_done_q ? '0 : {24'd0, PAD_MARKER};
                    marker_done_d = 1'b1;
                    widx_d        = widx_q + 4'd1;
                    if (widx_q == 4'd15) begin
                        state_d      = S_EMIT;
                        resume_pad_d = 1'b1;
                        emit_final_d = 1'b0;
                    end
                end
            end
            S_LEN: begin
                len_en       = 1'b1;
                state_d      = S_EMIT;
                emit_final_d = 1'b1;
            end
            S_EMIT: if (blk_ready) begin
                widx_d = '0;
                if (emit_final_q) begin
                    state_d       = S_FILL;
                    bytecnt_d     = '0;
                    blk_idx_d     = '0;
                    marker_done_d = 1'b0;
                end else begin
                    blk_idx_d = blk_idx_q + 32'd1;
                    state_d   = resume_pad_q ? S_PAD : S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // s_ready is gated by rst_n so no beat is offered while reset is held.
    always_comb begin
        s_ready   = state_q == S_FILL && rst_n;
        blk_valid = state_q == S_EMIT;
        blk_last  = blk_valid && emit_final_q;
        blk_idx   = blk_idx_q;
        blk_data  = '0;
        for (int i = 0; i < BLOCK_WORDS; i++)
            blk_data[32*i+:32] = buf_q[i];
    end

endmodule

// File: tb/tb_md5_pad.sv
// tb_md5_pad: scoreboard bench for md5_pad with directed and randomized messages.
module tb_md5_pad;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [31:0]  idx;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_nbytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    logic [31:0]  blk_idx;

    int           chk_cnt = 0;
    int           pass_cnt = 0;
    int           ready_mode = 0;
    blk_t         exp_q[$];
    logic [7:0]   msg_q[$];
    int           lens[14] = '{0, 1, 3, 4, 52, 55, 56, 57, 60, 63, 64, 119, 120, 128};

    md5_pad dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_nbytes(s_nbytes),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_idx(blk_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference: MD5 padding rule applied to the whole byte string.
    task automatic push_model();
        logic [7:0]  p[$];
        logic [63:0] bl;
        blk_t        e;
        int          nblk;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56)
            p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int b = 0; b < 8; b++)
            p.push_back(bl[8*b+:8]);
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++)
                e.data[8*j+:8] = p[64*k+j];
            e.last = (k == nblk - 1);
            e.idx  = 32'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_blk(input logic [511:0] d, input logic last, input logic [31:0] idx);
        blk_t e;
        e.data = d;
        e.last = last;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last, input logic [2:0] nbv);
        int t = 0;
        bit ok;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        s_nbytes = nbv;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 2000);
        if (!ok)
            chk("beat_accept_timeout", 512'(s_ready), 512'(1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input bit extra_empty, input bit gaps);
        int          n = msg_q.size();
        int          i = 0;
        logic [31:0] w;
        logic [2:0]  nbv;
        while (n - i > 4 || (n - i == 4 && extra_empty)) begin
            for (int k = 0; k < 4; k++)
                w[8*k+:8] = msg_q[i+k];
            drive_beat(w, 1'b0, 3'($urandom));
            i += 4;
            if (gaps)
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        w = $urandom;
        for (int k = 0; k < n - i; k++)
            w[8*k+:8] = msg_q[i+k];
        nbv = (n - i == 4 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(5, 7)) : 3'(n - i);
        drive_beat(w, 1'b1, nbv);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", 512'(exp_q.size()), 512'(0));
    endtask

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            blk_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        bit           stalled = 1'b0;
        logic [511:0] hold_data = '0;
        logic [31:0]  hold_idx = '0;
        blk_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 512'(blk_valid), 512'(1));
                    chk("hold_data", blk_data, hold_data);
                    chk("hold_idx", 512'(blk_idx), 512'(hold_idx));
                end
                if (blk_valid)
                    chk("emit_s_ready", 512'(s_ready), 512'(0));
                if (blk_valid && blk_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block", 512'(blk_valid), 512'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_data", blk_data, e.data);
                        chk("blk_last", 512'(blk_last), 512'(e.last));
                        chk("blk_idx", 512'(blk_idx), 512'(e.idx));
                    end
                end
                stalled   = blk_valid && !blk_ready;
                hold_data = blk_data;
                hold_idx  = blk_idx;
            end
        end
    end

    initial begin
        logic [511:0] d;
        logic [511:0] cap;
        int           t;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        s_nbytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blk_valid", 512'(blk_valid), 512'(0));
        chk("rst_s_ready", 512'(s_ready), 512'(0));
        chk("rst_blk_last", 512'(blk_last), 512'(0));
        chk("rst_blk_idx", 512'(blk_idx), 512'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty message.
        msg_q = {};
        push_blk(512'h80, 1'b1, 32'd0);
        drive_beat(32'h0, 1'b1, 3'd0);
        wait_drain();

        // "abc"
        d = '0;
        d[31:0]       = 32'h80636261;
        d[14*32+:32]  = 32'h00000018;
        push_blk(d, 1'b1, 32'd0);
        drive_beat(32'h00636261, 1'b1, 3'd3);
        wait_drain();

        // 56 bytes: marker and length split across two blocks.
        msg_q = {};
        for (int j = 0; j < 56; j++)
            msg_q.push_back(8'(j + 1));
        d = '0;
        for (int j = 0; j < 56; j++)
            d[8*j+:8] = 8'(j + 1);
        d[14*32+:32] = 32'h00000080;
        push_blk(d, 1'b0, 32'd0);
        d = '0;
        d[14*32+:32] = 32'h000001C0;
        push_blk(d, 1'b1, 32'd1);
        send_msg(1'b0, 1'b1);
        wait_drain();

        // 64 bytes with the first block held for 20 cycles.
        ready_mode = 2;
        msg_q = {};
        for (int j = 0; j < 64; j++)
            msg_q.push_back(8'hA0 ^ 8'(j));
        d = '0;
        for (int j = 0; j < 64; j++)
            d[8*j+:8] = 8'hA0 ^ 8'(j);
        push_blk(d, 1'b0, 32'd0);
        d = '0;
        d[31:0]      = 32'h00000080;
        d[14*32+:32] = 32'h00000200;
        push_blk(d, 1'b1, 32'd1);
        send_msg(1'b0, 1'b0);
        t = 0;
        while (!blk_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("stall_reach_valid", 512'(blk_valid), 512'(1));
        cap = blk_data;
        repeat (20) begin
            @(negedge clk);
            chk("stall_valid", 512'(blk_valid), 512'(1));
            chk("stall_data", blk_data, cap);
            chk("stall_idx", 512'(blk_idx), 512'(0));
            chk("stall_s_ready", 512'(s_ready), 512'(0));
        end
        ready_mode = 0;
        wait_drain();

        // Randomized messages: boundary lengths then random lengths.
        ready_mode = 1;
        for (int m = 0; m < 30; m++) begin
            msg_q = {};
            t = m < 14 ? lens[m] : int'($urandom_range(0, 150));
            for (int j = 0; j < t; j++)
                msg_q.push_back(8'($urandom));
            push_model();
            send_msg(1'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain();

        // Reset while padding, then "abc" must come out clean.
        ready_mode = 0;
        drive_beat(32'h00636261, 1'b1, 3'd3);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_blk_valid", 512'(blk_valid), 512'(0));
        chk("midrst_s_ready", 512'(s_ready), 512'(0));
        chk("midrst_blk_idx", 512'(blk_idx), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d = '0;
        d[31:0]      = 32'h80636261;
        d[14*32+:32] = 32'h00000018;
        push_blk(d, 1'b1, 32'd0);
        drive_beat(32'h00636261, 1'b1, 3'd3);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/md5_pad.md
MD5_PAD -- requirements
Module: md5_pad

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 s_valid  in  1  message word valid.
REQ-004 s_ready  out  1  pad stage accepts word; beat transfers when s_valid && s_ready.
REQ-005 s_data  in  32  message word, little-endian: byte k at s_data[8k+:8].
REQ-006 s_last  in  1  beat is final word of message.
REQ-007 s_nbytes  in  3  valid bytes in final beat, 0..4; ignored unless s_last; values 5..7 treated as 4.
REQ-008 blk_valid  out  1  512-bit padded block available.
REQ-009 blk_ready  in  1  downstream MD5 core takes block; transfer when blk_valid && blk_ready.
REQ-010 blk_data  out  512  block; word i at blk_data[32i+:32].
REQ-011 blk_last  out  1  block carries length field (final block of message).
REQ-012 blk_idx  out  32  zero-based index of current block within message.

Function
REQ-013 States: S_FILL, S_PAD, S_LEN, S_EMIT; word index widx (4 bits), byte counter bytecnt (61 bits), marker_done flag, emit_final flag, resume_pad flag.
REQ-014 S_FILL: s_ready=1; accepted beat written to word widx, widx+1, bytecnt+4 (non-last) or +s_nbytes (last).
REQ-015 Non-last beat with widx==15: go S_EMIT, emit_final=0, resume_pad=0.
REQ-016 Last beat: bytes >= s_nbytes zeroed; if s_nbytes<4, byte s_nbytes set to 0x80 and marker_done=1, else marker_done=0; next state S_PAD, or S_EMIT with resume_pad=1 if widx==15.
REQ-017 S_PAD: s_ready=0; if widx==14 && marker_done go S_LEN without writing; else write word widx = marker_done ? 0 : 0x00000080, set marker_done=1, widx+1; if written widx was 15 go S_EMIT with resume_pad=1, emit_final=0.
REQ-018 S_LEN: word14 = (bytecnt<<3)[31:0], word15 = (bytecnt<<3)[63:32]; go S_EMIT, emit_final=1.
REQ-019 S_EMIT: blk_valid=1, blk_last=emit_final, blk_data and blk_idx stable until transfer; s_ready=0.
REQ-020 On S_EMIT transfer: widx=0; emit_final -> S_FILL, bytecnt=0, blk_idx=0, marker_done=0; else blk_idx+1 and S_PAD if resume_pad else S_FILL.
REQ-021 Bit length modulo 2^64; bytecnt wraps silently.
REQ-022 Latency: last beat at widx w<=13 with s_nbytes<4 -> blk_valid in cycle (14-w)+1 after acceptance; each padding-only word costs one cycle.
REQ-023 blk_valid never deasserts without transfer; blk_ready while blk_valid=0 has no effect.
REQ-024 Empty message: single last beat with s_nbytes=0 yields one block, word0=0x00000080, length 0.

Reset
REQ-025 rst_n low: state S_FILL, widx=0, bytecnt=0, flags 0, blk_idx=0, blk_valid=0, blk_last=0, s_ready=0 while asserted; blk_data not reset.
REQ-026 Reset mid-message (any state) discards partial block and counter; first beat after release starts a new message.

Structure
REQ-027 Shared package md5_pkg holds state enum, WORD_LEN=32, BLOCK_WORDS=16, PAD_MARKER=8'h80, LEN_LO_IDX=14, LEN_HI_IDX=15.
REQ-028 Single flat module; 16x32 block buffer as register array; no sub-module.

Verification
REQ-029 Empty message (s_data=0, s_nbytes=0, s_last) -> one block, word0=0x00000080, words1..15=0, blk_last=1; fed to md5 gives d41d8cd98f00b204e9800998ecf8427e.
REQ-030 "abc" (s_data=0x00636261, s_nbytes=3, s_last) -> word0=0x80636261, word14=0x00000018, word15=0, blk_last=1, blk_idx=0.
REQ-031 56-byte message (14 full beats, last s_nbytes=4) -> block0 word14=0x80, word15=0, blk_last=0; block1 words0..13=0, word14=0x000001C0, blk_last=1, blk_idx=1.
REQ-032 64-byte message (16 full beats) -> block0 = data, blk_last=0; block1 word0=0x80, word14=0x00000200, blk_last=1.
REQ-033 blk_ready low 20 cycles during S_EMIT -> blk_valid, blk_data, blk_idx stable, s_ready=0 throughout.
REQ-034 rst_n pulsed low during S_PAD -> blk_valid=0 immediately; subsequent "abc" yields REQ-030 block exactly.
